game_display_sequencer: RTL and testbench
=========================================

GAME_DISPLAY_SEQUENCER -- requirements
Module: game_display_sequencer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 1000, clk cycles per timing tick (>=2).
REQ-002 SHALL provide parameter PLAY_TICKS, default 50, PLAY timeout in ticks (>=1).
REQ-003 SHALL provide parameter SHOW_TICKS, default 20, PASS/FAIL dwell in ticks (>=1).
REQ-004 SHALL provide parameter BLINK_TICKS, default 5, FAIL blink half-period in ticks (>=1).
REQ-005 SHALL provide port clk  in  1  single system clock; all logic on rising edge.
REQ-006 SHALL provide port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL provide port start  in  1  one-cycle start request.
REQ-008 SHALL provide port result_valid  in  1  round result offered.
REQ-009 SHALL provide port result_pass  in  1  result value, 1=pass 0=fail; meaningful only with result_valid.
REQ-010 SHALL provide port result_ready  out  1  result accepted this cycle when high with result_valid.
REQ-011 SHALL provide port display  out  2  code for display driver: 0 StAy, 1 PLAy, 2 PASS, 3 FAIL.
REQ-012 SHALL provide port blank  out  1  request display driver blank all digits.
REQ-013 SHALL provide port streak  out  4  consecutive passes, saturating.
REQ-014 SHALL provide port busy  out  1  high in any state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE, PLAY, PASS, FAIL; display = 0/1/2/3 respectively, decoded from state register (Moore, no combinational input-to-output path).
REQ-016 SHALL contain prescaler 0..TICK_DIV-1; tick asserted when prescaler = TICK_DIV-1, prescaler then wraps to 0; tick counter increments on tick.
REQ-017 SHALL clear prescaler, tick counter and blink counter on every state transition, so dwell = N*TICK_DIV cycles exactly.
REQ-018 IDLE: start=1 -> PLAY next cycle; otherwise stay; ticks have no effect.
REQ-019 PLAY: result_ready=1; in all other states result_ready=0.
REQ-020 PLAY: result_valid=1 -> PASS if result_pass=1 else FAIL, next cycle.
REQ-021 PLAY: no result and tick with tick counter = PLAY_TICKS-1 -> FAIL (timeout).
REQ-022 Result and timeout in same cycle: result SHALL win.
REQ-023 PASS/FAIL: tick with tick counter = SHOW_TICKS-1 -> IDLE.
REQ-024 start SHALL be ignored outside IDLE (no queuing); result_valid SHALL be ignored outside PLAY.
REQ-025 blank SHALL be 0 in IDLE, PLAY, PASS and on FAIL entry.
REQ-026 FAIL: blank SHALL toggle on each tick completing BLINK_TICKS ticks since last toggle/entry.
REQ-027 streak SHALL increment on PLAY->PASS transition, saturating at 15 (stays 15).
REQ-028 streak SHALL clear to 0 on any PLAY->FAIL transition (result or timeout).
REQ-029 busy SHALL equal (state != IDLE), registered with state.
REQ-030 Counters SHALL be sized to hold max parameter value; no wrap before terminal compare.

Reset
REQ-031 rst=1 at a clock edge SHALL force state IDLE, display 0, blank 0, result_ready 0, busy 0, streak 0, all counters 0, overriding every other input.
REQ-032 Reset asserted mid-PLAY/PASS/FAIL SHALL abandon the round; a result_valid concurrent with rst SHALL not be accepted and SHALL not change streak.
REQ-033 First cycle after rst deasserts SHALL accept start normally.

Verification (TICK_DIV=4, PLAY_TICKS=3, SHOW_TICKS=2, BLINK_TICKS=1)
REQ-034 Reset, pulse start, result_valid=1 result_pass=1 two cycles later -> display 0,1,2; streak=1; PASS held 8 cycles; then display=0, busy=0.
REQ-035 Start, no result -> FAIL exactly 12 cycles after PLAY entry; streak=0; blank 0 for 4 cycles then 1 for 4; IDLE after 8 cycles.
REQ-036 result_valid=1 result_pass=0 on the cycle the 3rd PLAY tick fires -> FAIL via result, single transition, streak cleared.
REQ-037 16 consecutive pass rounds -> streak reaches 15 and holds; one fail round -> streak=0.
REQ-038 start pulses during PLAY/PASS/FAIL and result_valid in IDLE -> no state change, result_ready stays 0 outside PLAY.
REQ-039 rst asserted for one cycle mid-FAIL with blank=1 -> next cycle display=0, blank=0, busy=0, streak=0; following start enters PLAY.

Source files
------------

// File: rtl/game_display_sequencer.sv
// Game display sequencer: IDLE -> PLAY -> PASS/FAIL -> IDLE round controller.
// Tick-based dwell timing, blinking FAIL display and a saturating pass streak.
module game_display_sequencer #(
  parameter int TICK_DIV    = 1000,
  parameter int PLAY_TICKS  = 50,
  parameter int SHOW_TICKS  = 20,
  parameter int BLINK_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       result_valid,
  input  logic       result_pass,
  output logic       result_ready,
  output logic [1:0] display,
  output logic       blank,
  output logic [3:0] streak,
  output logic       busy
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (PLAY_TICKS > SHOW_TICKS) ? PLAY_TICKS : SHOW_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BLINK_TICKS + 1);

  // Encodings match the display codes so display is a direct state decode.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic          tick;
  logic          play_done;
  logic          show_done;
  logic          blink_done;
  logic          change;

  // Terminal-count decodes for the prescaler, tick counter and blink counter.
  always_comb begin
    tick       = (presc == PW'(TICK_DIV - 1));
    play_done  = tick && (tcnt == TW'(PLAY_TICKS - 1));
    show_done  = tick && (tcnt == TW'(SHOW_TICKS - 1));
    blink_done = tick && (bcnt == BW'(BLINK_TICKS - 1));
    change     = (state_nxt != state);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a result offered in PLAY takes priority over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = PLAY;
      PLAY: begin
        if (result_valid)   state_nxt = result_pass ? PASS : FAIL;
        else if (play_done) state_nxt = FAIL;
      end
      PASS: if (show_done) state_nxt = IDLE;
      FAIL: if (show_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    display      = state;
    busy         = (state != IDLE);
    result_ready = (state == PLAY);
  end

  // Prescaler, tick counter and blink counter; all restart on any transition.
  always_ff @(posedge clk) begin
    if (rst || change) begin
      presc <= '0;
      tcnt  <= '0;
      bcnt  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick && (state != IDLE)) tcnt <= tcnt + 1'b1;
      if (tick && (state == FAIL)) bcnt <= blink_done ? '0 : bcnt + 1'b1;
    end
  end

  // Blank flag: low on every entry, toggles every BLINK_TICKS ticks in FAIL.
  always_ff @(posedge clk) begin
    if (rst || change)                    blank <= 1'b0;
    else if ((state == FAIL) && blink_done) blank <= ~blank;
  end

  // Pass streak: saturating increment on PLAY->PASS, clear on PLAY->FAIL.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (state == PLAY) begin
      if (state_nxt == PASS) begin
        if (streak != 4'hF) streak <= streak + 1'b1;
      end else if (state_nxt == FAIL) begin
        streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_game_display_sequencer.sv
// Self-checking bench for game_display_sequencer with small timing parameters.
module tb_game_display_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       result_valid = 1'b0;
  logic       result_pass = 1'b0;
  logic       result_ready;
  logic [1:0] display;
  logic       blank;
  logic [3:0] streak;
  logic       busy;

  int unsigned tests = 0;
  int unsigned failed = 0;

  typedef struct packed {
    logic [1:0] display;
    logic       blank;
    logic       ready;
    logic [3:0] streak;
    logic       busy;
  } out_t;

  typedef struct {
    logic rst;
    logic start;
    logic rv;
    logic rp;
    out_t exp;
  } vec_t;

  out_t sb_q[$];

  game_display_sequencer #(
    .TICK_DIV   (4),
    .PLAY_TICKS (3),
    .SHOW_TICKS (2),
    .BLINK_TICKS(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .result_valid(result_valid),
    .result_pass (result_pass),
    .result_ready(result_ready),
    .display     (display),
    .blank       (blank),
    .streak      (streak),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  // Expected outputs: ready only in PLAY (code 1), busy whenever not IDLE.
  function automatic out_t o(input logic [1:0] d, input logic b, input logic [3:0] s);
    out_t r;
    r.display = d;
    r.blank   = b;
    r.ready   = (d == 2'd1);
    r.streak  = s;
    r.busy    = (d != 2'd0);
    return r;
  endfunction

  task automatic check(input string name);
    out_t e;
    out_t a;
    e = sb_q.pop_front();
    a.display = display;
    a.blank   = blank;
    a.ready   = result_ready;
    a.streak  = streak;
    a.busy    = busy;
    tests++;
    if (a !== e) begin
      failed++;
      $display("FAIL %s: got display=%0d blank=%0b ready=%0b streak=%0d busy=%0b, want display=%0d blank=%0b ready=%0b streak=%0d busy=%0b",
               name, a.display, a.blank, a.ready, a.streak, a.busy,
               e.display, e.blank, e.ready, e.streak, e.busy);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v, input logic p,
                      input out_t e, input string name);
    rst = r; start = s; result_valid = v; result_pass = p;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic idle(input int unsigned n, input logic [1:0] d, input logic b,
                      input logic [3:0] s, input string name);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, o(d, b, s), name);
  endtask

  task automatic pass_round(input logic [3:0] prev, input logic [3:0] after);
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, prev), "pr_start");
    step(1'b0, 1'b0, 1'b0, 1'b0, o(2'd1, 1'b0, prev), "pr_play");
    step(1'b0, 1'b0, 1'b1, 1'b1, o(2'd2, 1'b0, after), "pr_pass");
    idle(7, 2'd2, 1'b0, after, "pr_dwell");
    idle(1, 2'd0, 1'b0, after, "pr_idle");
  endtask

  vec_t vecs[14];

  initial begin
    logic [3:0] s_prev;
    logic [3:0] s_next;

    // Reset, start right after reset release, pass two cycles later, PASS dwell.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, o(2'd0, 1'b0, 4'd0)};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, o(2'd0, 1'b0, 4'd0)};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd0)};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd0)};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, o(2'd2, 1'b0, 4'd1)};
    for (int i = 5; i < 12; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, o(2'd2, 1'b0, 4'd1)};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, o(2'd0, 1'b0, 4'd1)};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, o(2'd0, 1'b0, 4'd1)};

    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++)
      step(vecs[i].rst, vecs[i].start, vecs[i].rv, vecs[i].rp, vecs[i].exp, $sformatf("vec%0d", i));

    // Timeout: FAIL 12 cycles after PLAY entry, blank 0x4 then 1x4, then IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd1), "to_start");
    idle(11, 2'd1, 1'b0, 4'd1, "to_play");
    idle(1, 2'd3, 1'b0, 4'd0, "to_fail");
    idle(3, 2'd3, 1'b0, 4'd0, "to_blank0");
    idle(4, 2'd3, 1'b1, 4'd0, "to_blank1");
    idle(1, 2'd0, 1'b0, 4'd0, "to_idle");

    // Result coinciding with the timeout tick wins: pass then fail variants.
    pass_round(4'd0, 4'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd1), "rw_start");
    idle(11, 2'd1, 1'b0, 4'd1, "rw_play");
    step(1'b0, 1'b0, 1'b1, 1'b1, o(2'd2, 1'b0, 4'd2), "rw_pass");
    idle(7, 2'd2, 1'b0, 4'd2, "rw_pdwell");
    idle(1, 2'd0, 1'b0, 4'd2, "rw_pidle");
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd2), "rf_start");
    idle(11, 2'd1, 1'b0, 4'd2, "rf_play");
    step(1'b0, 1'b0, 1'b1, 1'b0, o(2'd3, 1'b0, 4'd0), "rf_fail");
    idle(3, 2'd3, 1'b0, 4'd0, "rf_blank0");
    idle(4, 2'd3, 1'b1, 4'd0, "rf_blank1");
    idle(1, 2'd0, 1'b0, 4'd0, "rf_idle");

    // Sixteen pass rounds saturate the streak at 15, one fail clears it.
    s_prev = 4'd0;
    for (int unsigned r = 0; r < 16; r++) begin
      s_next = (r + 1 > 15) ? 4'd15 : 4'(r + 1);
      pass_round(s_prev, s_next);
      s_prev = s_next;
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd15), "sat_start");
    step(1'b0, 1'b0, 1'b1, 1'b0, o(2'd3, 1'b0, 4'd0), "sat_fail");
    idle(3, 2'd3, 1'b0, 4'd0, "sat_blank0");
    idle(4, 2'd3, 1'b1, 4'd0, "sat_blank1");
    idle(1, 2'd0, 1'b0, 4'd0, "sat_idle");

    // Ignored start outside IDLE and ignored results outside PLAY.
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd0), "ig_start");
    for (int unsigned i = 0; i < 11; i++)
      step(1'b0, (i % 3 == 0), 1'b0, 1'b0, o(2'd1, 1'b0, 4'd0), "ig_play_start");
    idle(1, 2'd3, 1'b0, 4'd0, "ig_fail");
    for (int unsigned i = 0; i < 7; i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, o(2'd3, (i >= 3), 4'd0), "ig_fail_inputs");
    idle(1, 2'd0, 1'b0, 4'd0, "ig_fidle");
    step(1'b0, 1'b0, 1'b1, 1'b1, o(2'd0, 1'b0, 4'd0), "ig_idle_result");
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd0), "ig_p_start");
    step(1'b0, 1'b0, 1'b1, 1'b1, o(2'd2, 1'b0, 4'd1), "ig_p_pass");
    for (int unsigned i = 0; i < 7; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, o(2'd2, 1'b0, 4'd1), "ig_pass_inputs");
    idle(1, 2'd0, 1'b0, 4'd1, "ig_pidle");

    // Reset mid-FAIL while blanking, then a start right after release.
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd1), "rs_start");
    idle(11, 2'd1, 1'b0, 4'd1, "rs_play");
    idle(1, 2'd3, 1'b0, 4'd0, "rs_fail");
    idle(3, 2'd3, 1'b0, 4'd0, "rs_blank0");
    idle(2, 2'd3, 1'b1, 4'd0, "rs_blank1");
    step(1'b1, 1'b0, 1'b1, 1'b1, o(2'd0, 1'b0, 4'd0), "rs_reset");
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd0), "rs_restart");

    // Reset concurrent with an offered pass in PLAY discards it.
    step(1'b0, 1'b0, 1'b1, 1'b1, o(2'd2, 1'b0, 4'd1), "rp_pass");
    idle(7, 2'd2, 1'b0, 4'd1, "rp_dwell");
    idle(1, 2'd0, 1'b0, 4'd1, "rp_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, o(2'd1, 1'b0, 4'd1), "rp_start");
    step(1'b1, 1'b0, 1'b1, 1'b1, o(2'd0, 1'b0, 4'd0), "rp_reset");
    step(1'b0, 1'b0, 1'b1, 1'b1, o(2'd0, 1'b0, 4'd0), "rp_after");

    if (sb_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
